// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

  // Reference operand width; the divider itself is parameterised.
  localparam int unsigned DIV_WIDTH = 4;

  // Iteration counter width for a given operand width (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_w(DIV_WIDTH);

  // Fill bit for the all-ones quotient reported on divide by zero.
  localparam logic DBZ_FILL = 1'b1;

endpackage

// File: rtl/trial_sub.sv
// Two's-complement trial subtractor: diff = a + ~b + 1, carry-out = no-borrow (a >= b).
module trial_sub #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_no_borrow
);

  logic [W:0] w_sum;

  // One extra bit holds the carry-out of the subtract.
  assign w_sum       = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, 1'b1};
  assign o_diff      = w_sum[W-1:0];
  assign o_no_borrow = w_sum[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int unsigned CntW = cnt_w(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  div_state_e      r_state;
  logic [WIDTH:0]  r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic [CntW-1:0] r_cnt;
  logic            r_dbz;
  logic            r_busy;
  logic            r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic            r_div_by_zero;

  logic [WIDTH:0]  w_s;
  logic [WIDTH:0]  w_t;
  logic            w_no_borrow;
  logic [WIDTH:0]  w_p_next;

  // Shift the next dividend bit into the partial remainder before the trial subtract.
  assign w_s      = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_p_next = w_no_borrow ? w_t : w_s;

  trial_sub #(
    .W(WIDTH + 1)
  ) u_trial_sub (
    .i_a        (w_s),
    .i_b        ({1'b0, r_divisor}),
    .o_diff     (w_t),
    .o_no_borrow(w_no_borrow)
  );

  // Controller, datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_p           <= '0;
      r_q           <= '0;
      r_divisor     <= '0;
      r_cnt         <= '0;
      r_dbz         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          // Results are published while leaving DONE, so a request accepted here cannot
          // overwrite them before the done pulse.
          if (r_state == StDone) begin
            r_done        <= 1'b1;
            r_quotient    <= r_q;
            r_remainder   <= r_p[WIDTH-1:0];
            r_div_by_zero <= r_dbz;
          end
          if (i_start) begin
            r_divisor <= i_divisor;
            if (i_divisor != '0) begin
              r_state <= StCalc;
              r_busy  <= 1'b1;
              r_cnt   <= CntLast;
              r_p     <= '0;
              r_q     <= i_dividend;
              r_dbz   <= 1'b0;
            end else begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_q     <= {WIDTH{DBZ_FILL}};
              r_p     <= {1'b0, i_dividend};
              r_dbz   <= 1'b1;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StCalc: begin
          r_p <= w_p_next;
          r_q <= {r_q[WIDTH-2:0], w_no_borrow};
          if (r_cnt == '0) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned restoring divider that sits downstream of the two's-complement subtract stage (A + ~B + 1).
- Each cycle it performs one trial subtraction and uses the carry-out as the no-borrow flag: a result of 1 means A >= B.
- Produces the quotient and remainder of dividend / divisor after WIDTH iterations.
- Valid/done handshake toward the consuming logic.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on clk, accepted only in IDLE or DONE.
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge.
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; quotient/remainder valid in that cycle.
- quotient  output  WIDTH  result; held stable until the next accepted start.
- remainder  output  WIDTH  result; held stable until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor == 0; held with the results.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert use): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers (partial remainder, quotient shift register, iteration counter) cleared.
- States: IDLE, CALC, DONE.
- IDLE: start=1 -> capture operands. If divisor != 0: go to CALC, counter=WIDTH-1, partial remainder P (WIDTH+1 bits)=0, Q=dividend. If divisor == 0: go straight to DONE. start=0 -> stay in IDLE.
- CALC, one iteration per edge:
  - S = {P[WIDTH-1:0], Q[WIDTH-1]}, WIDTH+1 bits.
  - Trial T = S + ~{1'b0,divisor} + 1, computed at WIDTH+1 bits; the carry-out is no_borrow.
  - If no_borrow: P=T and the new Q LSB is 1. Otherwise P=S (restore) and the new Q LSB is 0.
  - Q shifts left by one each iteration.
  - Counter==0 -> go to DONE; otherwise decrement.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - quotient=Q and remainder=P[WIDTH-1:0] are registered on entry to DONE.
  - Divide by zero: quotient=all ones, remainder=dividend, div_by_zero=1.
  - Next state: start=1 -> accepted exactly as from IDLE (back-to-back operation); start=0 -> IDLE.
- Latency, taking the accepting edge as edge 0:
  - Normal: done high in the cycle after edge WIDTH+1, i.e. 5 edges for WIDTH=4; busy high for WIDTH cycles.
  - Divide by zero: done high after edge 1.
- start while in CALC is ignored; the operands already captured are unaffected.
- done is never high in consecutive cycles unless a back-to-back divide-by-zero request is accepted in DONE.
- Outputs quotient, remainder and div_by_zero change only on entry to DONE or on reset.
- div_by_zero is cleared on entry to DONE for a nonzero divisor.
- Reset mid-CALC aborts immediately to the reset values; no done pulse is generated.
- Width rule: the trial subtract is WIDTH+1 bits wide so that S up to 2*divisor-1 never overflows. The final remainder always satisfies remainder < divisor.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - localparam CNT_W = $clog2(WIDTH);
  - the constant for the all-ones divide-by-zero quotient.
- Sub-module trial_sub, parameterised to WIDTH+1 bits:
  - combinational a + ~b + 1;
  - outputs diff and no_borrow (the carry-out);
  - instantiated once in the CALC datapath.

Test Plan:
- Normal case: dividend=13, divisor=4, start pulse -> busy high 4 cycles; done pulse after edge 5; quotient=3, remainder=1, div_by_zero=0.
- Divisor of one: dividend=15, divisor=1 -> quotient=15, remainder=0. Divisor larger than dividend: dividend=3, divisor=9 -> quotient=0, remainder=3.
- Divide by zero: dividend=7, divisor=0 -> done after edge 1; quotient=15, remainder=7, div_by_zero=1, busy never high. A following 10/5 -> quotient=2, remainder=0, div_by_zero=0.
- Busy handling: start 13/4, then start with 15/1 asserted during CALC -> ignored, result stays 3 r1. Start 12/5 asserted in the DONE cycle -> accepted; results 2 r2 after 5 more edges.
- Reset mid-operation: rst_n low during CALC -> outputs zero immediately, no done pulse. A fresh 9/3 after release -> quotient=3, remainder=0.
- Exhaustive check: all 256 (dividend, divisor) pairs at WIDTH=4 against a reference model. Covers quotient, remainder and div_by_zero, plus done timing of 5 edges for a nonzero divisor and 1 edge for zero.
